// File: rtl/npc_pkg.sv
// Shared next-PC definitions for the F stage, CP0 and the hazard unit.
package npc_pkg;

    typedef enum logic [3:0] {
        NPC_SEQ  = 4'd0,
        NPC_BEQ  = 4'd1,
        NPC_BNE  = 4'd2,
        NPC_BLEZ = 4'd3,
        NPC_BGTZ = 4'd4,
        NPC_BLTZ = 4'd5,
        NPC_BGEZ = 4'd6,
        NPC_J    = 4'd7,
        NPC_JR   = 4'd8
    } npc_op_e;

    localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NPC_EXC_PC   = 32'h0000_4180;

endpackage

// File: rtl/npc_fetch_ctrl_branch_cmp.sv
// Conditional-branch resolver: signed compares of the forwarded D-stage operands.
module branch_cmp
    import npc_pkg::*;
(
    input  logic [3:0]  npc_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        taken
);

    logic signed [31:0] rs_s;

    assign rs_s = rs_data;

    always_comb begin
        taken = 1'b0;
        case (npc_op_e'(npc_op))
            NPC_BEQ:  taken = (rs_data == rt_data);
            NPC_BNE:  taken = (rs_data != rt_data);
            NPC_BLEZ: taken = (rs_s <= 32'sd0);
            NPC_BGTZ: taken = (rs_s >  32'sd0);
            NPC_BLTZ: taken = (rs_s <  32'sd0);
            NPC_BGEZ: taken = (rs_s >= 32'sd0);
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/npc_fetch_ctrl.sv
// F-stage PC register and instruction-fetch request controller with a
// one-entry buffer for exception/eret redirects that arrive mid-request.
module npc_fetch_ctrl
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = NPC_RESET_PC,
    parameter logic [31:0] EXC_PC   = NPC_EXC_PC,
    parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [3:0]  npc_op,
    input  logic [31:0] pc_D,
    input  logic [31:0] rs_data_D,
    input  logic [31:0] rt_data_D,
    input  logic [15:0] imm_D,
    input  logic [25:0] j_address_D,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    output logic [31:0] pc_F,
    output logic        adel_F,
    output logic        fetch_busy
);

    logic        pend_v;
    logic [31:0] pend_pc;
    logic        taken;
    logic        adv;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] npc_res;
    logic [31:0] redir_pc;

    branch_cmp u_branch_cmp (
        .npc_op  (npc_op),
        .rs_data (rs_data_D),
        .rt_data (rt_data_D),
        .taken   (taken)
    );

    assign adel_F     = (pc_F[1:0] != 2'b00) | (pc_F < IMEM_LO) | (pc_F > IMEM_HI);
    assign imem_req   = reset_n & ~adel_F;
    assign imem_addr  = pc_F;
    assign fetch_busy = imem_req & ~imem_gnt;
    // An illegal PC is never issued, so it must not block redirects.
    assign adv        = adel_F | (imem_req & imem_gnt);

    always_comb begin
        br_target = pc_D + 32'd4 + {{14{imm_D[15]}}, imm_D, 2'b00};
        j_target  = {pc_D[31:28], j_address_D, 2'b00};
        npc_res   = pc_F + 32'd4;
        case (npc_op_e'(npc_op))
            NPC_J:   npc_res = j_target;
            NPC_JR:  npc_res = rs_data_D;
            default: if (taken) npc_res = br_target;
        endcase
        redir_pc = exc_req ? EXC_PC : epc;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_F    <= RESET_PC;
            pend_v  <= 1'b0;
            pend_pc <= '0;
        end else if (exc_req | eret_req) begin
            if (adv) begin
                pc_F <= redir_pc;
            end else begin
                pend_v  <= 1'b1;
                pend_pc <= redir_pc;
            end
        end else if (pend_v) begin
            if (adv) begin
                pc_F   <= pend_pc;
                pend_v <= 1'b0;
            end
        end else if (!(stall | fetch_busy)) begin
            pc_F <= npc_res;
        end
    end

endmodule

// File: tb/tb_npc_fetch_ctrl.sv
// Directed plus randomized bench for npc_fetch_ctrl against a behavioural PC model.
module tb_npc_fetch_ctrl;

    localparam logic [31:0] LO   = 32'h0000_3000;
    localparam logic [31:0] HI   = 32'h0000_6FFC;
    localparam logic [31:0] RPC  = 32'h0000_3000;
    localparam logic [31:0] XPC  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset_n, stall, exc_req, eret_req, imem_gnt;
    logic [3:0]  npc_op;
    logic [31:0] pc_D, rs_data_D, rt_data_D, epc;
    logic [15:0] imm_D;
    logic [25:0] j_address_D;
    logic        imem_req, adel_F, fetch_busy;
    logic [31:0] imem_addr, pc_F;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] m_pc, m_pend_pc;
    logic        m_pend_v;
    logic        e_adel, e_req, e_busy, e_adv;

    npc_fetch_ctrl #(
        .RESET_PC (RPC),
        .EXC_PC   (XPC),
        .IMEM_LO  (LO),
        .IMEM_HI  (HI)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .npc_op      (npc_op),
        .pc_D        (pc_D),
        .rs_data_D   (rs_data_D),
        .rt_data_D   (rt_data_D),
        .imm_D       (imm_D),
        .j_address_D (j_address_D),
        .exc_req     (exc_req),
        .eret_req    (eret_req),
        .epc         (epc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .pc_F        (pc_F),
        .adel_F      (adel_F),
        .fetch_busy  (fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Next PC from the D-stage op, computed arithmetically from the branch rules.
    function automatic logic [31:0] m_npc();
        longint rs, rt;
        bit t;
        rs = longint'($signed(rs_data_D));
        rt = longint'($signed(rt_data_D));
        t = 1'b0;
        case (npc_op)
            4'd1: t = (rs == rt);
            4'd2: t = (rs != rt);
            4'd3: t = (rs <= 0);
            4'd4: t = (rs > 0);
            4'd5: t = (rs < 0);
            4'd6: t = (rs >= 0);
            4'd7: return (pc_D & 32'hF000_0000) | (32'(j_address_D) * 32'd4);
            4'd8: return rs_data_D;
            default: t = 1'b0;
        endcase
        if (t) return 32'(longint'(pc_D) + 4 + longint'($signed(imm_D)) * 4);
        return m_pc + 32'd4;
    endfunction

    task automatic idle();
        reset_n = 1'b1; stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
        imem_gnt = 1'b1; npc_op = 4'd0; pc_D = 32'h3000; rs_data_D = '0;
        rt_data_D = '0; imm_D = '0; j_address_D = '0; epc = 32'h3000;
    endtask

    task automatic settle();
        #1;
        e_adel = (m_pc % 4 != 0) || (m_pc < LO) || (m_pc > HI);
        e_req  = reset_n && !e_adel;
        e_busy = e_req && !imem_gnt;
        e_adv  = e_adel || (e_req && imem_gnt);
        check("pc_F", pc_F, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("adel_F", 32'(adel_F), 32'(e_adel));
        check("imem_req", 32'(imem_req), 32'(e_req));
        check("fetch_busy", 32'(fetch_busy), 32'(e_busy));
        check("pend_v", 32'(dut.pend_v), 32'(m_pend_v));
    endtask

    task automatic advance();
        logic [31:0] tgt;
        if (!reset_n) begin
            m_pc = RPC;
            m_pend_v = 1'b0;
        end else if (exc_req || eret_req) begin
            tgt = exc_req ? XPC : epc;
            if (e_adv) m_pc = tgt;
            else begin
                m_pend_v  = 1'b1;
                m_pend_pc = tgt;
            end
        end else if (m_pend_v) begin
            if (e_adv) begin
                m_pc = m_pend_pc;
                m_pend_v = 1'b0;
            end
        end else if (!(stall || e_busy)) begin
            m_pc = m_npc();
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        m_pc = RPC; m_pend_v = 1'b0; m_pend_pc = '0;

        // reset state
        settle();
        check("rst_req", 32'(imem_req), 32'd0);
        advance();

        // sequential fetch
        idle();
        for (int i = 0; i < 4; i++) begin
            settle();
            check("seq_addr", imem_addr, 32'h3000 + 32'(i) * 4);
            advance();
        end

        // BNE taken backwards
        npc_op = 4'd2; pc_D = 32'h3004; rs_data_D = 32'd1; rt_data_D = 32'd2; imm_D = 16'hFFFE;
        settle(); advance();
        idle(); settle(); check("bne_taken", pc_F, 32'h3000); advance();
        // BNE not taken
        npc_op = 4'd2; pc_D = 32'h3004; rs_data_D = 32'd5; rt_data_D = 32'd5; imm_D = 16'hFFFE;
        settle(); advance();
        idle(); settle(); check("bne_fall", pc_F, 32'h3008);
        // BLTZ on most-negative value
        npc_op = 4'd5; pc_D = 32'h3004; rs_data_D = 32'h8000_0000; imm_D = 16'h0002;
        settle(); advance();
        idle(); settle(); check("bltz", pc_F, 32'h3010);

        // grant withheld while a taken BEQ sits in D
        npc_op = 4'd1; pc_D = 32'h300C; rs_data_D = 32'd7; rt_data_D = 32'd7; imm_D = 16'h0010;
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hold_addr", imem_addr, 32'h3010);
            check("hold_busy", 32'(fetch_busy), 32'd1);
            advance();
        end
        imem_gnt = 1'b1;
        settle(); advance();
        idle(); settle(); check("beq_after_gnt", pc_F, 32'h3050);
        npc_op = 4'd8; rs_data_D = 32'h3020;
        settle(); advance();

        // exception buffered during a stalled request
        idle(); imem_gnt = 1'b0; exc_req = 1'b1;
        settle(); check("exc_hold0", imem_addr, 32'h3020); advance();
        exc_req = 1'b0;
        settle(); check("exc_hold1", imem_addr, 32'h3020); check("exc_pend", 32'(dut.pend_v), 32'd1); advance();
        imem_gnt = 1'b1;
        settle(); advance();
        idle(); settle(); check("exc_taken", pc_F, 32'h4180); check("exc_pend_clr", 32'(dut.pend_v), 32'd0);

        // misaligned JR target, then AdEL exception
        npc_op = 4'd8; rs_data_D = 32'h3002;
        settle(); advance();
        idle(); exc_req = 1'b1;
        settle(); check("adel_flag", 32'(adel_F), 32'd1); check("adel_noreq", 32'(imem_req), 32'd0); advance();
        idle(); settle(); check("adel_exc", pc_F, 32'h4180);
        eret_req = 1'b1; epc = 32'h3040;
        settle(); advance();
        idle(); settle(); check("eret", pc_F, 32'h3040); advance();

        // reset discards a pending redirect
        imem_gnt = 1'b0; exc_req = 1'b1;
        settle(); advance();
        idle(); reset_n = 1'b0; imem_gnt = 1'b0;
        settle(); check("rst_drop_req", 32'(imem_req), 32'd0); advance();
        idle(); settle(); check("rst_pc", pc_F, 32'h3000); check("rst_pend", 32'(dut.pend_v), 32'd0); advance();
        settle(); check("no_stale", pc_F, 32'h3004); advance();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 99) >= 2);
            stall     = ($urandom_range(0, 99) < 20);
            imem_gnt  = ($urandom_range(0, 99) < 70);
            exc_req   = ($urandom_range(0, 99) < 5);
            eret_req  = ($urandom_range(0, 99) < 6);
            npc_op    = 4'($urandom_range(0, 15));
            pc_D      = 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 4;
            imm_D     = 16'($signed($urandom_range(0, 255)) - 128);
            j_address_D = 26'h0000C00 + 26'($urandom_range(0, 32'hFFF));
            rt_data_D = $urandom;
            case ($urandom_range(0, 5))
                0: rs_data_D = '0;
                1: rs_data_D = 32'h8000_0000;
                2: rs_data_D = rt_data_D;
                3: rs_data_D = 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 4;
                4: rs_data_D = 32'h3000 + 32'($urandom_range(0, 32'h3FFF));
                default: rs_data_D = $urandom;
            endcase
            epc = ($urandom_range(0, 9) == 0) ? 32'h3001 : 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 4;
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
